// File: rtl/pwm_pr_pkg.sv
// Shared constants for the pwm_pr PWM block.
package pwm_pr_pkg;

  localparam int DEFAULT_PERIOD = 8;

endpackage : pwm_pr_pkg

// File: rtl/pwm_pr_if.sv
// Duty-in / PWM-out bundle; the master supplies the duty, the slave produces the pulse.
interface pwm_pr_if
  import pwm_pr_pkg::*;
#(
  parameter int period = DEFAULT_PERIOD
);

  localparam int W = $clog2(period);

  logic [W-1:0] in;
  logic         out;

  modport master (output in, input out);
  modport slave  (input in, output out);

endinterface : pwm_pr_if

// File: rtl/pwm_pr.sv
// Fixed-period PWM: duty is latched once per frame at the phase wrap, so the
// output never changes shape mid-frame.
module pwm_pr
  import pwm_pr_pkg::*;
#(
  parameter int period = DEFAULT_PERIOD
) (
  input  logic    clk,
  input  logic    rst,
  pwm_pr_if.slave bus
);

  localparam int           W       = $clog2(period);
  localparam logic [W-1:0] PH_LAST = W'(period - 1);

  logic [W-1:0] ph_q, ph_d;
  logic [W-1:0] d_q, d_d;
  logic         out_q, out_d;
  logic         boundary;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    boundary = 1'b0;
    ph_d     = ph_q;
    d_d      = d_q;
    out_d    = 1'b0;

    // Explicit compare against period-1 so non-power-of-two periods wrap on time.
    boundary = (ph_q == PH_LAST);
    if (boundary) begin
      ph_d = '0;
      d_d  = bus.in;
    end else begin
      ph_d = ph_q + W'(1);
    end

    // ph_d never exceeds period-1, so any d >= period yields a constant high.
    out_d = (ph_d < d_d);
  end

  // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q  <= PH_LAST;
      d_q   <= '0;
      out_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      d_q   <= d_d;
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule : pwm_pr

// File: tb/tb_pwm_pr.sv
// Directed checks of pwm_pr at period 8 and period 5; outputs sampled on the falling edge.
module tb_pwm_pr;

  logic clk;
  logic rst8;
  logic rst5;

  int vectors     = 0;
  int miscompares = 0;

  pwm_pr_if #(.period(8)) if8 ();
  pwm_pr_if #(.period(5)) if5 ();

  pwm_pr #(.period(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8));
  pwm_pr #(.period(5)) dut5 (.clk(clk), .rst(rst5), .bus(if5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Both instances held in reset: outputs must be low on every reset edge.
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (if8.out !== 1'b0) begin
        miscompares++;
        $display("FAIL reset8 cyc%0d: got %b want 0", i, if8.out);
      end
      vectors++;
      if (if5.out !== 1'b0) begin
        miscompares++;
        $display("FAIL reset5 cyc%0d: got %b want 0", i, if5.out);
      end
    end
  endtask

  // in=3 from release: 1,1,1,0,0,0,0,0 every frame, first 1 on the first edge.
  task automatic test_basic(input logic [2:0] nxt);
    logic exp_pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    if8.in = 3'd3;
    rst8   = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        vectors++;
        if (if8.out !== exp_pat[k]) begin
          miscompares++;
          $display("FAIL basic f%0d k%0d: got %b want %b", f, k, if8.out, exp_pat[k]);
        end
        if (f == 2 && k == 7) if8.in = nxt;
      end
    end
  endtask

  // Duty changed to 6 at phase 4: current frame stays 3-high, later frames 6-high.
  task automatic test_midframe(input logic [2:0] nxt);
    logic exp_v;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        exp_v = (f == 0) ? (k < 3) : (k < 6);
        vectors++;
        if (if8.out !== exp_v) begin
          miscompares++;
          $display("FAIL midframe f%0d k%0d: got %b want %b", f, k, if8.out, exp_v);
        end
        if (f == 0 && k == 4) if8.in = 3'd6;
        if (f == 2 && k == 7) if8.in = nxt;
      end
    end
  endtask

  // in=0 stays low for 4 frames, then in=7 gives 7 high / 1 low.
  task automatic test_zero_full(input logic [2:0] nxt);
    logic exp_v;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        exp_v = (f < 4) ? 1'b0 : (k < 7);
        vectors++;
        if (if8.out !== exp_v) begin
          miscompares++;
          $display("FAIL zero_full f%0d k%0d: got %b want %b", f, k, if8.out, exp_v);
        end
        if (f == 3 && k == 7) if8.in = 3'd7;
        if (f == 5 && k == 7) if8.in = nxt;
      end
    end
  endtask

  // Reset asserted at phase 1 with in=6; release restarts a full 6-high frame.
  task automatic test_reset_midframe(input logic [2:0] nxt);
    logic exp_v;
    @(negedge clk);
    vectors++;
    if (if8.out !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid pre: got %b want 1", if8.out);
    end
    rst8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (if8.out !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid held%0d: got %b want 0", i, if8.out);
      end
    end
    rst8 = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        exp_v = (k < 6);
        vectors++;
        if (if8.out !== exp_v) begin
          miscompares++;
          $display("FAIL rstmid f%0d k%0d: got %b want %b", f, k, if8.out, exp_v);
        end
        if (f == 1 && k == 7) if8.in = nxt;
      end
    end
  endtask

  // in scrambled on every non-boundary cycle; only the boundary values matter.
  task automatic test_random_in();
    logic [2:0] bvals [4] = '{3'd2, 3'd5, 3'd1, 3'd7};
    logic       exp_v;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        exp_v = (k < int'(bvals[f]));
        vectors++;
        if (if8.out !== exp_v) begin
          miscompares++;
          $display("FAIL random f%0d k%0d: got %b want %b", f, k, if8.out, exp_v);
        end
        if (k == 7) if8.in = (f < 3) ? bvals[f+1] : 3'd0;
        else        if8.in = 3'($urandom_range(0, 7));
      end
    end
  endtask

  // period=5: in=2 gives 11000, in=5 and in=7 saturate high, then back to 3 and 1.
  task automatic test_p5();
    int   duty [6] = '{2, 2, 5, 7, 3, 1};
    logic exp_v;
    if5.in = 3'd2;
    rst5   = 1'b0;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        exp_v = (k < duty[f]);
        vectors++;
        if (if5.out !== exp_v) begin
          miscompares++;
          $display("FAIL p5 f%0d k%0d: got %b want %b", f, k, if5.out, exp_v);
        end
        if (k == 4 && f < 5) if5.in = 3'(duty[f+1]);
      end
    end
  endtask

  initial begin
    rst8   = 1'b1;
    rst5   = 1'b1;
    if8.in = 3'd3;
    if5.in = 3'd0;

    test_reset();
    test_basic(3'd3);
    test_midframe(3'd0);
    test_zero_full(3'd6);
    test_reset_midframe(3'd2);
    test_random_in();
    test_p5();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pwm_pr

// File: doc/pwm_pr.md
# pwm_pr

Fixed-period pulse-width modulator with a period-registered duty input. A free-running phase counter divides time into frames of `period` clock cycles. The duty value `in` is sampled once per frame, at the frame boundary, so mid-frame changes never produce glitches or partial pulses. It drives a single digital output, such as an LED, a gate driver or an RC DAC, from a system-clock-domain duty value.

## Interface
- `period`, default 8: frame length in clock cycles; integer ≥ 2.
- `W`, derived, not overridable: `$clog2(period)`; width of `in`.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in` input W: requested duty, in clock cycles of high time per frame.
- `out` input/output: `out` is an output, 1 bit, registered PWM signal.

## Operation
- State:
  - phase counter `ph`, 0..period-1;
  - duty register `d`, W bits;
  - output register `out`.
- Frame boundary: the clock edge on which `ph` advances from period-1 to 0. On that edge `d <= in`.
- All other edges: `ph <= ph + 1`, `d` holds.
- Output rule: during frame phase k (0..period-1), `out` = 1 iff k < d, where `d` is the value latched for that frame.
  - High time per frame is exactly `min(d, period)` cycles, contiguous, starting at phase 0.
- Limits of `in`:
  - `in` = 0: `out` constant 0.
  - When `period` is a power of two, maximum `in` = period-1 gives (period-1)/period duty; 100 % is not reachable.
  - When `period` is not a power of two, any `in` ≥ period gives constant 1 (saturation, no wrap).
- `in` is sampled only at frame boundaries; its value on other edges is ignored.

## Timing
- Reset, on any edge with `rst`=1, including mid-frame:
  - `ph <= period-1`;
  - `d <= 0`;
  - `out <= 0`.
- The first edge with `rst`=0 is a frame boundary:
  - `in` is sampled;
  - that edge begins phase 0;
  - `out` on that edge becomes `(0 < in)`.
- Registered output: the value of `out` for phase k is produced on the edge that enters phase k.
  - Compute it from next-state values, i.e. `out <= (ph_next < d_next)`.
  - No combinational path from `in` to `out`.
- Latency: a change of `in` takes effect at the next frame boundary.
  - Worst case `period` cycles; best case 1 cycle, if it changes just before the boundary.
- Frame length is exactly `period` cycles, including the first frame after reset. Counter wrap has no dead cycle.

## Structure
- No shared package entries needed; `W` is a local derived constant.
- Single flat module; no sub-modules.
- Phase counter width is `$clog2(period)` bits. Compare with `period-1` explicitly, not by natural overflow, so non-power-of-two periods wrap correctly.
- Saturating compare is done at W+1 bits, or the natural compare already yields 1 when d ≥ period.

## Test plan
1. period=8, in=3, release reset -> `out` repeats 1,1,1,0,0,0,0,0 each 8-cycle frame; the first 1 appears on the first edge after reset release.
2. period=8, in=3, change in to 6 at phase 4 -> current frame finishes 3-high/5-low; the next frame onward is 6 high, 2 low.
3. period=8, in=0 -> `out` stays 0 for at least 4 frames. Then in=7 -> 7 high, 1 low per frame.
4. period=5 (W=3): in=2 -> 2 high, 3 low; in=5 and in=7 -> `out` constant 1; frame length 5 cycles verified by boundary sampling.
5. Reset mid-frame: assert `rst` at phase 1 with in=6 -> `out`=0 on that edge and while held. Release -> new frame starts at phase 0 with full 6-cycle high time.
6. Toggle `in` randomly on every non-boundary cycle -> `out` pattern depends only on `in` values at boundary edges; no runt pulses.
